// File: rtl/tron_pkg.sv
// Shared tron constants: directions, screen limits, player start words and the
// 18-bit player word layout {alive, dir[1:0], x[7:0], y[6:0]}.
package tron_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam int SCR_X_MAX = 159;
    localparam int SCR_Y_MAX = 119;

    localparam int PW_W       = 18;
    localparam int PW_ALIVE   = 17;
    localparam int PW_DIR_LSB = 15;
    localparam int PW_X_LSB   = 7;
    localparam int PW_Y_LSB   = 0;

    // Start words carry alive=0; a round start sets the alive bit.
    localparam logic [PW_W-1:0] P1_START = {1'b0, DIR_RIGHT, 8'd20,  7'd60};
    localparam logic [PW_W-1:0] P2_START = {1'b0, DIR_LEFT,  8'd139, 7'd60};
    localparam logic [PW_W-1:0] P3_START = {1'b0, DIR_DOWN,  8'd80,  7'd10};
    localparam logic [PW_W-1:0] P4_START = {1'b0, DIR_UP,    8'd80,  7'd109};

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_RUN, S_MOVE0, S_MOVE1, S_MOVE2, S_MOVE3, S_CHECK, S_OVER
    } mover_state_e;

endpackage

// File: rtl/rate_divider.sv
// Free-running modulo-DIV counter; pulse is high in the cycle the count is DIV-1.
module rate_divider #(
    parameter int DIV = 833333
) (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic clear,
    output logic pulse
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign pulse = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || pulse) cnt_d = '0;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/player_mover.sv
// Owns position/heading/alive of the four players and steps them once per game tick.
// Define PLAYER_MOVER_WRAP_EN to wrap at the screen edges instead of killing.
module player_mover
    import tron_pkg::*;
#(
    parameter int TICK_DIV = 833333,
    parameter int X_MAX    = SCR_X_MAX,
    parameter int Y_MAX    = SCR_Y_MAX
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic [4:0]  KEY_PRESSED,
    input  logic        start,
    output logic [17:0] p1,
    output logic [17:0] p2,
    output logic [17:0] p3,
    output logic [17:0] p4,
    output logic        tick,
    output logic        game_over,
    output logic [2:0]  winner
);
`ifdef PLAYER_MOVER_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif
    localparam logic [7:0] XM = 8'(X_MAX);
    localparam logic [6:0] YM = 7'(Y_MAX);
    localparam logic [3:0][PW_W-1:0] START_W = {P4_START, P3_START, P2_START, P1_START};

    mover_state_e           state_q, state_d;
    logic                   start_q;
    logic [3:0][PW_W-1:0]   pw_q, pw_d;
    logic [3:0]             pend_vld_q, pend_vld_d;
    logic [3:0][1:0]        pend_dir_q, pend_dir_d;
    logic [2:0]             winner_q, winner_d;
    logic                   div_clear, div_pulse;
    logic [3:0]             kill, alive_post;
    logic                   mv_en;
    logic [1:0]             mv, hd;

    function automatic logic [PW_W-1:0] next_pos(input logic [PW_W-1:0] w, input logic [1:0] d);
        logic [PW_W-1:0] r;
        logic [7:0]      x;
        logic [6:0]      y;
        logic            wall;
        x = w[PW_X_LSB +: 8];
        y = w[PW_Y_LSB +: 7];
        case (d)
            DIR_UP:    begin wall = (y == '0); y = wall ? YM : y - 7'd1; end
            DIR_RIGHT: begin wall = (x == XM); x = wall ? '0 : x + 8'd1; end
            DIR_DOWN:  begin wall = (y == YM); y = wall ? '0 : y + 7'd1; end
            default:   begin wall = (x == '0); x = wall ? XM : x - 8'd1; end
        endcase
        if (wall && !WRAP_EN) begin
            // Killed in place: keep the old position, record the attempted heading.
            r = w;
            r[PW_ALIVE] = 1'b0;
            r[PW_DIR_LSB +: 2] = d;
        end else begin
            r = {1'b1, d, x, y};
        end
        return r;
    endfunction

    rate_divider #(.DIV(TICK_DIV)) u_div (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .clear    (div_clear),
        .pulse    (div_pulse)
    );

    // The divider keeps running through the move pass so ticks stay TICK_DIV apart.
    assign div_clear = (state_q == S_IDLE) || (state_q == S_INIT) || (state_q == S_OVER);
    assign tick      = div_pulse && (state_q == S_RUN);
    assign game_over = (state_q == S_OVER);
    assign winner    = winner_q;
    assign p1        = pw_q[0];
    assign p2        = pw_q[1];
    assign p3        = pw_q[2];
    assign p4        = pw_q[3];

    always_comb begin
        kill       = '0;
        alive_post = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (i != j && pw_q[i][PW_ALIVE] && pw_q[j][PW_ALIVE] &&
                    pw_q[i][PW_DIR_LSB-1:0] == pw_q[j][PW_DIR_LSB-1:0])
                    kill[i] = 1'b1;
            end
            alive_post[i] = pw_q[i][PW_ALIVE] && !kill[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        pw_d       = pw_q;
        pend_vld_d = pend_vld_q;
        pend_dir_d = pend_dir_q;
        winner_d   = winner_q;
        mv_en      = 1'b0;
        mv         = 2'd0;
        hd         = 2'd0;
        case (state_q)
            S_IDLE, S_OVER: if (start && !start_q) state_d = S_INIT;
            S_INIT: begin
                for (int i = 0; i < 4; i++) begin
                    pw_d[i]           = START_W[i];
                    pw_d[i][PW_ALIVE] = 1'b1;
                end
                pend_vld_d = '0;
                winner_d   = '0;
                state_d    = S_RUN;
            end
            S_RUN:   if (div_pulse) state_d = S_MOVE0;
            S_MOVE0: begin mv_en = 1'b1; mv = 2'd0; state_d = S_MOVE1; end
            S_MOVE1: begin mv_en = 1'b1; mv = 2'd1; state_d = S_MOVE2; end
            S_MOVE2: begin mv_en = 1'b1; mv = 2'd2; state_d = S_MOVE3; end
            S_MOVE3: begin mv_en = 1'b1; mv = 2'd3; state_d = S_CHECK; end
            S_CHECK: begin
                for (int i = 0; i < 4; i++)
                    if (kill[i]) pw_d[i][PW_ALIVE] = 1'b0;
                if ($countones(alive_post) <= 1) begin
                    state_d  = S_OVER;
                    winner_d = '0;
                    for (int i = 0; i < 4; i++)
                        if (alive_post[i]) winner_d = 3'(i + 1);
                end else begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (mv_en) begin
            if (pw_q[mv][PW_ALIVE]) begin
                hd = pw_q[mv][PW_DIR_LSB +: 2];
                // XOR with 2'b10 gives the opposite heading; a U-turn request is dropped.
                if (pend_vld_q[mv] && pend_dir_q[mv] != (hd ^ 2'b10)) hd = pend_dir_q[mv];
                pw_d[mv] = next_pos(pw_q[mv], hd);
            end
            pend_vld_d[mv] = 1'b0;
        end

        // After the MOVE clear, so a strobe landing in MOVEn carries to the next tick.
        if (KEY_PRESSED[4] && state_q != S_IDLE && state_q != S_OVER) begin
            pend_vld_d[KEY_PRESSED[3:2]] = 1'b1;
            pend_dir_d[KEY_PRESSED[3:2]] = KEY_PRESSED[1:0];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            pw_q       <= START_W;
            pend_vld_q <= '0;
            pend_dir_q <= '0;
            winner_q   <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start;
            pw_q       <= pw_d;
            pend_vld_q <= pend_vld_d;
            pend_dir_q <= pend_dir_d;
            winner_q   <= winner_d;
        end
    end
endmodule

// File: tb/tb_player_mover.sv
// Directed bench for player_mover with TICK_DIV=8; expected words are hand-computed.
module tb_player_mover;
    localparam int TD = 8;
`ifdef PLAYER_MOVER_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  kp = '0;
    logic [17:0] p1, p2, p3, p4;
    logic        tick, game_over;
    logic [2:0]  winner;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_prev   = 0;
    int t_cur    = 0;

    player_mover #(.TICK_DIV(TD)) dut (
        .CLOCK_50    (clk),
        .resetn      (resetn),
        .KEY_PRESSED (kp),
        .start       (start),
        .p1          (p1),
        .p2          (p2),
        .p3          (p3),
        .p4          (p4),
        .tick        (tick),
        .game_over   (game_over),
        .winner      (winner)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [17:0] pw(input logic a, input logic [1:0] d, input int x, input int y);
        return {a, d, 8'(x), 7'(y)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_words(input string tag, input logic [17:0] e1, input logic [17:0] e2,
                             input logic [17:0] e3, input logic [17:0] e4);
        chk({tag, "_p1"}, 32'(p1), 32'(e1));
        chk({tag, "_p2"}, 32'(p2), 32'(e2));
        chk({tag, "_p3"}, 32'(p3), 32'(e3));
        chk({tag, "_p4"}, 32'(p4), 32'(e4));
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < 4 * TD);
        chk("tick_seen", 32'(tick), 32'd1);
        t_prev = t_cur;
        t_cur  = cyc;
    endtask

    // Tick in cycle T; MOVE0..3 in T+1..T+4, CHECK in T+5, results settled by T+6.
    task automatic run_pass();
        wait_tick();
        repeat (6) @(negedge clk);
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_pass();
    endtask

    task automatic key(input logic [1:0] pl, input logic [1:0] d);
        kp = {1'b1, pl, d};
        @(negedge clk);
        kp = '0;
    endtask

    task automatic new_round();
        if (WRAP) begin
            resetn = 1'b0;
            @(negedge clk);
            resetn = 1'b1;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic count_ticks(input int n, output int ticks);
        ticks = 0;
        repeat (n) begin
            @(negedge clk);
            if (tick === 1'b1) ticks++;
        end
    endtask

    initial begin
        int ticks;
        // Reset state
        repeat (2) @(negedge clk);
        chk_words("rst", pw(0,1,20,60), pw(0,3,139,60), pw(0,2,80,10), pw(0,0,80,109));
        resetn = 1'b1;
        count_ticks(30, ticks);
        chk("idle_ticks", 32'(ticks), 32'd0);
        chk("idle_go", 32'(game_over), 32'd0);
        chk("idle_win", 32'(winner), 32'd0);
        chk_words("idle", pw(0,1,20,60), pw(0,3,139,60), pw(0,2,80,10), pw(0,0,80,109));

        // Round 1: stepping, U-turn rejection, turns, p1/p3 head-on, p2 last survivor
        new_round();
        run_pass();
        chk_words("k1", pw(1,1,21,60), pw(1,3,138,60), pw(1,2,80,11), pw(1,0,80,108));
        key(2'd0, 2'd3);
        run_pass();
        chk("tick_period", 32'(t_cur - t_prev), 32'(TD));
        chk("rev_p1", 32'(p1), 32'(pw(1,1,22,60)));
        key(2'd0, 2'd0);
        run_pass();
        chk("up_p1", 32'(p1), 32'(pw(1,0,22,59)));
        key(2'd0, 2'd1);
        run_pass();
        chk("right_p1", 32'(p1), 32'(pw(1,1,23,59)));
        run_n(45);
        chk("k49_p3", 32'(p3), 32'(pw(1,2,80,59)));
        key(2'd2, 2'd3);
        run_pass();
        chk("k50_p3", 32'(p3), 32'(pw(1,3,79,59)));
        chk("k50_p1", 32'(p1), 32'(pw(1,1,69,59)));
        run_n(5);
        chk_words("hit", pw(0,1,74,59), pw(1,3,84,60), pw(0,3,74,59), pw(1,0,80,54));
        chk("hit_go", 32'(game_over), 32'd0);
        run_n(55);
        chk("k110_p4", 32'(p4), 32'(WRAP ? pw(1,0,80,119) : pw(0,0,80,0)));
        chk("k110_p2", 32'(p2), 32'(pw(1,3,29,60)));
        chk("r1_go", 32'(game_over), 32'(WRAP ? 0 : 1));
        chk("r1_win", 32'(winner), 32'(WRAP ? 0 : 2));
        count_ticks(20, ticks);
        chk("over_ticks", 32'(ticks), 32'(WRAP ? 3 : 0));

        // Round 2: no steering; walls kill p3/p4 then p1/p2 on the same tick
        new_round();
        run_n(110);
        chk("w110_p3", 32'(p3), 32'(WRAP ? pw(1,2,80,0) : pw(0,2,80,119)));
        chk("w110_p4", 32'(p4), 32'(WRAP ? pw(1,0,80,119) : pw(0,0,80,0)));
        chk("w110_p1", 32'(p1), 32'(pw(1,1,130,60)));
        chk("w110_go", 32'(game_over), 32'd0);
        run_n(29);
        chk("w139_p1", 32'(p1), 32'(pw(1,1,159,60)));
        chk("w139_p2", 32'(p2), 32'(pw(1,3,0,60)));
        run_pass();
        chk("w140_p1", 32'(p1), 32'(WRAP ? pw(1,1,0,60) : pw(0,1,159,60)));
        chk("w140_p2", 32'(p2), 32'(WRAP ? pw(1,3,159,60) : pw(0,3,0,60)));
        chk("w140_p3", 32'(p3), 32'(WRAP ? pw(1,2,80,30) : pw(0,2,80,119)));
        chk("w140_go", 32'(game_over), 32'(WRAP ? 0 : 1));
        chk("w140_win", 32'(winner), 32'd0);

        // Round 3: p1 down, p2 up, p4 right; p3 is last alive
        new_round();
        key(2'd0, 2'd2);
        key(2'd1, 2'd0);
        key(2'd3, 2'd1);
        run_n(60);
        chk("s60_p1", 32'(p1), 32'(WRAP ? pw(1,2,20,0) : pw(0,2,20,119)));
        run_pass();
        chk("s61_p2", 32'(p2), 32'(WRAP ? pw(1,0,139,119) : pw(0,0,139,0)));
        run_n(19);
        chk("s80_p4", 32'(p4), 32'(WRAP ? pw(1,1,0,109) : pw(0,1,159,109)));
        chk("s80_p3", 32'(p3), 32'(pw(1,2,80,90)));
        chk("s80_go", 32'(game_over), 32'(WRAP ? 0 : 1));
        chk("s80_win", 32'(winner), 32'(WRAP ? 0 : 3));

        // Round 4: restart clears game_over/winner; async reset in MOVE2
        new_round();
        chk("r4_go", 32'(game_over), 32'd0);
        chk("r4_win", 32'(winner), 32'd0);
        wait_tick();
        repeat (3) @(negedge clk);
        chk("mv2_p1", 32'(p1), 32'(pw(1,1,21,60)));
        chk("mv2_p3", 32'(p3), 32'(pw(1,2,80,10)));
        resetn = 1'b0;
        #1;
        chk_words("arst", pw(0,1,20,60), pw(0,3,139,60), pw(0,2,80,10), pw(0,0,80,109));
        chk("arst_tick", 32'(tick), 32'd0);
        chk("arst_go", 32'(game_over), 32'd0);
        chk("arst_win", 32'(winner), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        count_ticks(20, ticks);
        chk("arst_ticks", 32'(ticks), 32'd0);
        chk("arst_p1", 32'(p1), 32'(pw(0,1,20,60)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
